// File: rtl/avalon_read_checker.sv
// Avalon-MM read-back checker: compares each readdatavalid beat against an incrementing expected pattern.
// Define AVALON_READ_CHECKER_CAPTURE_EN to build the first-mismatch capture registers.
module avalon_read_checker #(
    parameter int DATA_W         = 128,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] start_value,
    input  logic [CNT_W-1:0]  expected_beats,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic              stray,
    output logic [15:0]       error_count,
    output logic [CNT_W-1:0]  beat_count,
    output logic [CNT_W-1:0]  first_err_beat,
    output logic [DATA_W-1:0] first_err_data
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   expected_q, expected_d;
    logic [CNT_W-1:0]    target_q, target_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [CNT_W-1:0]    beat_count_q, beat_count_d;
    logic [15:0]         error_count_q, error_count_d;
    logic                timeout_q, timeout_d;
    logic                stray_q, stray_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                start_acc_s;
    logic                mismatch_s;
    logic                beat_s;

    assign start_acc_s = start && (state_q != S_CHECK);
    assign mismatch_s  = (avm_readdata != expected_q);
    assign beat_s      = avm_readdatavalid && (state_q == S_CHECK);

    // Next-state and result computation; beats take priority over the idle timeout.
    always_comb begin
        state_d       = state_q;
        expected_d    = expected_q;
        target_d      = target_q;
        idle_d        = idle_q;
        beat_count_d  = beat_count_q;
        error_count_d = error_count_q;
        timeout_d     = timeout_q;
        stray_d       = stray_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    expected_d    = start_value;
                    target_d      = expected_beats;
                    idle_d        = {IDLE_W{1'b0}};
                    beat_count_d  = {CNT_W{1'b0}};
                    error_count_d = 16'd0;
                    timeout_d     = 1'b0;
                    if (expected_beats == {CNT_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CHECK;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_CHECK: begin
                if (avm_readdatavalid) begin
                    if (mismatch_s && (error_count_q != 16'hFFFF)) begin
                        error_count_d = error_count_q + 16'd1;
                    end else begin
                        error_count_d = error_count_q;
                    end
                    beat_count_d = beat_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    expected_d   = expected_q + {{(DATA_W-1){1'b0}}, 1'b1};
                    idle_d       = {IDLE_W{1'b0}};
                    if (beat_count_d == target_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CHECK;
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    idle_d = idle_q + {{(IDLE_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (avm_readdatavalid && (state_q != S_CHECK)) begin
            stray_d = 1'b1;
        end else begin
            stray_d = stray_q;
        end

        busy_d = (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (error_count_d == 16'd0) && !timeout_d;
        fail_d = done_d && !pass_d;
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            expected_q    <= {DATA_W{1'b0}};
            target_q      <= {CNT_W{1'b0}};
            idle_q        <= {IDLE_W{1'b0}};
            beat_count_q  <= {CNT_W{1'b0}};
            error_count_q <= 16'd0;
            timeout_q     <= 1'b0;
            stray_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            expected_q    <= expected_d;
            target_q      <= target_d;
            idle_q        <= idle_d;
            beat_count_q  <= beat_count_d;
            error_count_q <= error_count_d;
            timeout_q     <= timeout_d;
            stray_q       <= stray_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
        end
    end

`ifdef AVALON_READ_CHECKER_CAPTURE_EN
    logic [CNT_W-1:0]  first_err_beat_q, first_err_beat_d;
    logic [DATA_W-1:0] first_err_data_q, first_err_data_d;

    // Capture the first mismatch of a run; a zero error count marks "nothing captured yet".
    always_comb begin
        first_err_beat_d = first_err_beat_q;
        first_err_data_d = first_err_data_q;
        if (start_acc_s) begin
            first_err_beat_d = {CNT_W{1'b0}};
            first_err_data_d = {DATA_W{1'b0}};
        end else if (beat_s && mismatch_s && (error_count_q == 16'd0)) begin
            first_err_beat_d = beat_count_q;
            first_err_data_d = avm_readdata;
        end else begin
            first_err_beat_d = first_err_beat_q;
            first_err_data_d = first_err_data_q;
        end
    end

    // Capture registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_err_beat_q <= {CNT_W{1'b0}};
            first_err_data_q <= {DATA_W{1'b0}};
        end else begin
            first_err_beat_q <= first_err_beat_d;
            first_err_data_q <= first_err_data_d;
        end
    end

    assign first_err_beat = first_err_beat_q;
    assign first_err_data = first_err_data_q;
`else
    logic unused_s;
    assign unused_s       = start_acc_s ^ beat_s;
    assign first_err_beat = {CNT_W{1'b0}};
    assign first_err_data = {DATA_W{1'b0}};
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign stray       = stray_q;
    assign error_count = error_count_q;
    assign beat_count  = beat_count_q;

endmodule

// File: tb/tb_avalon_read_checker.sv
// Self-checking bench for avalon_read_checker: table of runs plus hand-written corner sequences,
// with a per-beat scoreboard of expected beat/error counts.
module tb_avalon_read_checker;
    localparam int DW = 128;
    localparam int CW = 32;
    localparam int TO = 16;
`ifdef AVALON_READ_CHECKER_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, start, avm_readdatavalid;
    logic [DW-1:0] start_value, avm_readdata;
    logic [CW-1:0] expected_beats;
    logic          busy, done, pass, fail, timeout, stray;
    logic [15:0]   error_count;
    logic [CW-1:0] beat_count, first_err_beat;
    logic [DW-1:0] first_err_data;

    int checks = 0;
    int errors = 0;
    int m_err;

    typedef struct {
        logic [31:0] cnt;
        logic [15:0] err;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [127:0] sv;
        int           beats;
        int           sent;
        int           bad0;
        int           bad1;
        int           gap;
        bit           exp_pass;
        int           exp_err;
        bit           exp_to;
        int           exp_feb;
        logic [127:0] exp_fed;
    } run_t;
    run_t runs[5];

    avalon_read_checker #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_value(start_value),
        .expected_beats(expected_beats), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .busy(busy), .done(done), .pass(pass),
        .fail(fail), .timeout(timeout), .stray(stray), .error_count(error_count),
        .beat_count(beat_count), .first_err_beat(first_err_beat), .first_err_data(first_err_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [127:0] sv, input int beats);
        start          = 1'b1;
        start_value    = sv;
        expected_beats = beats;
        cyc();
        start = 1'b0;
        m_err = 0;
    endtask

    task automatic send_beat(input logic [127:0] exp_data, input logic [127:0] data,
                             input int idx, input int beats);
        sb_t e;
        if (data !== exp_data && m_err < 65535) m_err++;
        e.cnt = idx + 1;
        e.err = m_err;
        sb.push_back(e);
        avm_readdatavalid = 1'b1;
        avm_readdata      = data;
        cyc();
        avm_readdatavalid = 1'b0;
        e = sb.pop_front();
        chk("beat_count", {96'd0, beat_count}, {96'd0, e.cnt});
        chk("error_count", {112'd0, error_count}, {112'd0, e.err});
        chk("done_after_beat", {127'd0, done}, {127'd0, (idx + 1 == beats)});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
        chk({tag, "_done"}, {127'd0, done}, 128'd0);
        chk({tag, "_pass"}, {127'd0, pass}, 128'd0);
        chk({tag, "_fail"}, {127'd0, fail}, 128'd0);
        chk({tag, "_timeout"}, {127'd0, timeout}, 128'd0);
        chk({tag, "_stray"}, {127'd0, stray}, 128'd0);
        chk({tag, "_error_count"}, {112'd0, error_count}, 128'd0);
        chk({tag, "_beat_count"}, {96'd0, beat_count}, 128'd0);
        chk({tag, "_first_err_beat"}, {96'd0, first_err_beat}, 128'd0);
        chk({tag, "_first_err_data"}, first_err_data, 128'd0);
    endtask

    task automatic do_run(input run_t r);
        logic [127:0] exp_d, data;
        start_run(r.sv, r.beats);
        chk("busy_after_start", {127'd0, busy}, {127'd0, (r.beats != 0)});
        chk("done_after_start", {127'd0, done}, {127'd0, (r.beats == 0)});
        for (int i = 0; i < r.sent; i++) begin
            if (i > 0) repeat (r.gap) cyc();
            exp_d = r.sv + 128'(i);
            if (i == r.bad0) data = 128'hDEAD;
            else if (i == r.bad1) data = exp_d ^ (128'd1 << 100);
            else data = exp_d;
            send_beat(exp_d, data, i, r.beats);
        end
        if (r.exp_to) begin
            for (int c = 1; c <= TO; c++) begin
                cyc();
                chk("timeout_edge_done", {127'd0, done}, {127'd0, (c == TO)});
            end
        end
        chk("final_done", {127'd0, done}, 128'd1);
        chk("final_busy", {127'd0, busy}, 128'd0);
        chk("final_pass", {127'd0, pass}, {127'd0, r.exp_pass});
        chk("final_fail", {127'd0, fail}, {127'd0, !r.exp_pass});
        chk("final_timeout", {127'd0, timeout}, {127'd0, r.exp_to});
        chk("final_error_count", {112'd0, error_count}, 128'(r.exp_err));
        chk("final_beat_count", {96'd0, beat_count}, 128'(r.sent));
        chk("final_first_err_beat", {96'd0, first_err_beat}, 128'(r.exp_feb));
        chk("final_first_err_data", first_err_data, r.exp_fed);
    endtask

    initial begin
        logic [127:0] wrap_sv;
        wrap_sv = ~128'd1;
        //             sv       beats sent bad0 bad1 gap pass err to  feb              fed
        runs[0] = '{128'd0,    64,   64,  -1,  -1,  0,  1'b1, 0, 1'b0, 0,               128'd0};
        runs[1] = '{128'd0,    64,   64,  10,  20,  0,  1'b0, 2, 1'b0, CAP ? 10 : 0,    CAP ? 128'hDEAD : 128'd0};
        runs[2] = '{wrap_sv,   4,    4,   -1,  -1,  3,  1'b1, 0, 1'b0, 0,               128'd0};
        runs[3] = '{128'd100,  8,    5,   -1,  -1,  0,  1'b0, 0, 1'b1, 0,               128'd0};
        runs[4] = '{128'd5,    0,    0,   -1,  -1,  0,  1'b1, 0, 1'b0, 0,               128'd0};

        rst_n = 1'b0; start = 1'b0; avm_readdatavalid = 1'b0;
        start_value = 128'd0; avm_readdata = 128'd0; expected_beats = 32'd0; m_err = 0;
        repeat (2) cyc();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc();

        // Stray beat in IDLE.
        avm_readdatavalid = 1'b1; avm_readdata = 128'd7;
        cyc();
        avm_readdatavalid = 1'b0;
        chk("stray_set", {127'd0, stray}, 128'd1);
        chk("stray_beat_count", {96'd0, beat_count}, 128'd0);
        chk("stray_error_count", {112'd0, error_count}, 128'd0);
        chk("stray_busy", {127'd0, busy}, 128'd0);

        for (int k = 0; k < 5; k++) do_run(runs[k]);
        chk("stray_sticky", {127'd0, stray}, 128'd1);

        // start while checking is ignored.
        start_run(128'd0, 4);
        send_beat(128'd0, 128'd0, 0, 4);
        send_beat(128'd1, 128'd1, 1, 4);
        start = 1'b1; start_value = 128'd999; expected_beats = 32'd1;
        cyc();
        start = 1'b0;
        chk("ignored_start_busy", {127'd0, busy}, 128'd1);
        chk("ignored_start_beat_count", {96'd0, beat_count}, 128'd2);
        send_beat(128'd2, 128'd2, 2, 4);
        send_beat(128'd3, 128'd3, 3, 4);
        chk("ignored_start_pass", {127'd0, pass}, 128'd1);

        // Reset after beat 30 of 64, then a fresh clean run.
        start_run(128'd0, 64);
        for (int i = 0; i < 30; i++) send_beat(128'(i), 128'(i), i, 64);
        rst_n = 1'b0;
        cyc();
        check_reset_outputs("midrun_reset");
        rst_n = 1'b1;
        do_run(runs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
